// File: rtl/aw_w_b_channel.sv
// aw_w_b_channel: write-transaction stage of the sram-to-AXI bridge.
// Turns one data-sram write request into a single-beat AXI write (AW, W, B).
// Only one write may be in flight. busy and the pending address are exported
// so the read stage can hold off a read to the word still being written.
module aw_w_b_channel #(
   parameter logic [3:0] WR_ID = 4'd1
) (
   input  logic        clk,
   input  logic        reset,

   // data sram side
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_wr_addr_ok,
   output logic        data_sram_wr_data_ok,

   // hazard information for the read stage
   output logic        wr_busy,
   output logic [31:0] wr_pending_addr,
   output logic        wr_err,

   // AXI write address channel
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,

   // AXI write data channel
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,

   // AXI write response channel
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      RESP
   } state_t;

   state_t state;
   state_t state_next;

   logic        accept;
   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;
   logic        aw_fin;
   logic        w_fin;
   logic        send_done;
   logic        aw_done;
   logic        w_done;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  size_q;

   // The response id is not checked: only one write is ever outstanding.
   logic        unused_bid;
   assign unused_bid = ^bid;

   // A write is accepted only while idle; reads are left to the read stage.
   assign accept               = (state == IDLE) && data_sram_req && data_sram_wr;
   assign data_sram_wr_addr_ok = accept;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign b_hs  = bvalid && bready;

   // A channel counts as finished if it completed earlier or completes now,
   // so AW and W landing in the same cycle move straight on to RESP.
   assign aw_fin    = aw_done || aw_hs;
   assign w_fin     = w_done || w_hs;
   assign send_done = (state == SEND) && aw_fin && w_fin;

   assign wr_busy         = (state != IDLE);
   assign wr_pending_addr = addr_q;

   // Fixed single-beat incrementing burst fields.
   assign awid    = WR_ID;
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wid   = WR_ID;
   assign wdata = wdata_q;
   assign wstrb = wstrb_q;
   assign wlast = 1'b1;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept, wait for both AW and W, then wait for B.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (aw_fin && w_fin) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (b_hs) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture the request payload so AW/W stay stable until their handshakes.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         size_q  <= 2'd0;
      end else if (accept) begin
         addr_q  <= data_sram_addr;
         wdata_q <= data_sram_wdata;
         wstrb_q <= data_sram_wstrb;
         size_q  <= data_sram_size;
      end
   end

   // AW and W valids rise together on accept and each drops after its own handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
      end else if (accept) begin
         awvalid <= 1'b1;
         wvalid  <= 1'b1;
      end else begin
         if (aw_hs) begin
            awvalid <= 1'b0;
         end
         if (w_hs) begin
            wvalid <= 1'b0;
         end
      end
   end

   // Remember which of AW and W have already completed in this transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (accept) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state == SEND) begin
         if (aw_hs) begin
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            w_done <= 1'b1;
         end
      end
   end

   // bready is raised once both request channels are through and held until B arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         bready <= 1'b0;
      end else if (send_done) begin
         bready <= 1'b1;
      end else if (b_hs) begin
         bready <= 1'b0;
      end
   end

   // Completion pulse and error flag, both one cycle after the B handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_sram_wr_data_ok <= 1'b0;
         wr_err               <= 1'b0;
      end else begin
         data_sram_wr_data_ok <= b_hs;
         wr_err               <= b_hs && (bresp != 2'b00);
      end
   end

endmodule

// File: tb/tb_aw_w_b_channel.sv
// tb_aw_w_b_channel: randomized bench for the write-transaction stage.
// Expected behaviour comes from a per-transaction timeline: given the accept
// cycle and the ready/response delays the bench chooses, it knows in which
// relative cycle each valid, bready and data_ok must be high.
module tb_aw_w_b_channel;

   localparam logic [3:0] WR_ID = 4'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_wr_addr_ok;
   logic        data_sram_wr_data_ok;
   logic        wr_busy;
   logic [31:0] wr_pending_addr;
   logic        wr_err;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int checks = 0;
   int errors = 0;

   // Carry-over payload for a request held high across the previous write.
   logic [31:0] nx_addr;
   logic [31:0] nx_data;
   logic [3:0]  nx_strb;
   logic [1:0]  nx_size;

   always #5 clk = ~clk;

   aw_w_b_channel #(.WR_ID(WR_ID)) dut (
      .clk                  (clk),
      .reset                (reset),
      .data_sram_req        (data_sram_req),
      .data_sram_wr         (data_sram_wr),
      .data_sram_size       (data_sram_size),
      .data_sram_wstrb      (data_sram_wstrb),
      .data_sram_addr       (data_sram_addr),
      .data_sram_wdata      (data_sram_wdata),
      .data_sram_wr_addr_ok (data_sram_wr_addr_ok),
      .data_sram_wr_data_ok (data_sram_wr_data_ok),
      .wr_busy              (wr_busy),
      .wr_pending_addr      (wr_pending_addr),
      .wr_err               (wr_err),
      .awid                 (awid),
      .awaddr               (awaddr),
      .awlen                (awlen),
      .awsize               (awsize),
      .awburst              (awburst),
      .awlock               (awlock),
      .awcache              (awcache),
      .awprot               (awprot),
      .awvalid              (awvalid),
      .awready              (awready),
      .wid                  (wid),
      .wdata                (wdata),
      .wstrb                (wstrb),
      .wlast                (wlast),
      .wvalid               (wvalid),
      .wready               (wready),
      .bid                  (bid),
      .bresp                (bresp),
      .bvalid               (bvalid),
      .bready               (bready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle with no write: random read requests must be ignored.
   task automatic idleCycle();
      @(posedge clk);
      #1;
      reset           = 1'b0;
      data_sram_req   = 1'($urandom_range(0, 1));
      data_sram_wr    = 1'b0;
      data_sram_addr  = $urandom;
      data_sram_wdata = $urandom;
      awready         = 1'($urandom_range(0, 1));
      wready          = 1'($urandom_range(0, 1));
      bvalid          = 1'b0;
      #1;
      checkOutput("idle_addr_ok", 32'(data_sram_wr_addr_ok), 32'd0);
      checkOutput("idle_busy", 32'(wr_busy), 32'd0);
      checkOutput("idle_valids", {30'd0, awvalid, wvalid}, 32'd0);
      checkOutput("idle_bready", 32'(bready), 32'd0);
      checkOutput("idle_data_ok", 32'(data_sram_wr_data_ok), 32'd0);
   endtask

   // One complete write. da/dw: cycles awready/wready stay low after the
   // valids rise; db: cycles bvalid stays low after bready rises.
   // hold_next keeps a second write request asserted throughout; cont means
   // this write's accept cycle is the previous write's completion cycle.
   // reset_at >= 0 pulses reset in that relative cycle and aborts the write.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] size,
                                input int da, input int dw, input int db,
                                input logic [1:0] resp, input bit hold_next,
                                input bit cont, input int reset_at);
      int aw_hs_k;
      int w_hs_k;
      int rb_k;
      int b_hs_k;
      int ok_k;
      aw_hs_k = 1 + da;
      w_hs_k  = 1 + dw;
      rb_k    = ((aw_hs_k > w_hs_k) ? aw_hs_k : w_hs_k) + 1;
      b_hs_k  = rb_k + db;
      ok_k    = b_hs_k + 1;
      for (int k = 0; k <= ok_k; k++) begin
         if (!(k == 0 && cont)) begin
            @(posedge clk);
         end
         #1;
         reset = (k == reset_at);
         if (k == 0) begin
            data_sram_req   = 1'b1;
            data_sram_wr    = 1'b1;
            data_sram_addr  = addr;
            data_sram_wdata = data;
            data_sram_wstrb = strb;
            data_sram_size  = size;
         end else if (hold_next) begin
            data_sram_req   = 1'b1;
            data_sram_wr    = 1'b1;
            data_sram_addr  = nx_addr;
            data_sram_wdata = nx_data;
            data_sram_wstrb = nx_strb;
            data_sram_size  = nx_size;
         end else begin
            data_sram_req   = 1'($urandom_range(0, 1));
            data_sram_wr    = 1'b0;
            data_sram_addr  = $urandom;
            data_sram_wdata = $urandom;
         end
         awready = (k >= aw_hs_k);
         wready  = (k >= w_hs_k);
         bvalid  = (k == b_hs_k) && (k != reset_at);
         bresp   = (k == b_hs_k) ? resp : 2'($urandom_range(0, 3));
         bid     = WR_ID;
         #1;
         if (k == 0) begin
            checkOutput("accept_addr_ok", 32'(data_sram_wr_addr_ok), 32'd1);
            checkOutput("accept_busy", 32'(wr_busy), 32'd0);
            checkOutput("accept_data_ok", 32'(data_sram_wr_data_ok), 32'(cont));
         end else begin
            checkOutput("addr_ok", 32'(data_sram_wr_addr_ok), 32'((k == ok_k) && hold_next));
            checkOutput("busy", 32'(wr_busy), 32'(k <= b_hs_k));
            checkOutput("awvalid", 32'(awvalid), 32'(k <= aw_hs_k));
            checkOutput("wvalid", 32'(wvalid), 32'(k <= w_hs_k));
            checkOutput("bready", 32'(bready), 32'((k >= rb_k) && (k <= b_hs_k)));
            checkOutput("data_ok", 32'(data_sram_wr_data_ok), 32'(k == ok_k));
            checkOutput("pending_addr", wr_pending_addr, addr);
            if (k <= aw_hs_k) begin
               checkOutput("awaddr", awaddr, addr);
               checkOutput("aw_fields", {awid, awlen, awsize, awburst, awlock, awcache, awprot},
                           {WR_ID, 8'd0, 1'b0, size, 2'b01, 2'b00, 4'd0, 3'd0});
            end
            if (k <= w_hs_k) begin
               checkOutput("wdata", wdata, data);
               checkOutput("w_fields", {22'd0, wid, wstrb, wlast, 1'b0}, {22'd0, WR_ID, strb, 1'b1, 1'b0});
            end
            if (k == ok_k) begin
               checkOutput("wr_err", 32'(wr_err), 32'(resp != 2'b00));
            end
         end
         if (k == reset_at) begin
            @(posedge clk);
            #1;
            reset         = 1'b0;
            data_sram_req = 1'b0;
            awready       = 1'b0;
            wready        = 1'b0;
            bvalid        = 1'b0;
            #1;
            checkOutput("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
            checkOutput("rst_busy", 32'(wr_busy), 32'd0);
            checkOutput("rst_data_ok", 32'(data_sram_wr_data_ok), 32'd0);
            checkOutput("rst_pending", wr_pending_addr, 32'd0);
            @(posedge clk);
            #2;
            checkOutput("rst_no_pulse", 32'(data_sram_wr_data_ok), 32'd0);
            checkOutput("rst_still_idle", 32'(wr_busy), 32'd0);
            return;
         end
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [1:0]  z;
      bit          cont;
      bit          hold;

      reset           = 1'b1;
      data_sram_req   = 1'b0;
      data_sram_wr    = 1'b0;
      data_sram_size  = 2'd0;
      data_sram_wstrb = 4'd0;
      data_sram_addr  = 32'd0;
      data_sram_wdata = 32'd0;
      awready         = 1'b0;
      wready          = 1'b0;
      bid             = 4'd0;
      bresp           = 2'd0;
      bvalid          = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_busy", 32'(wr_busy), 32'd0);
      checkOutput("reset_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
      checkOutput("reset_data_ok_err", {30'd0, data_sram_wr_data_ok, wr_err}, 32'd0);
      checkOutput("reset_pending", wr_pending_addr, 32'd0);
      checkOutput("reset_payload", awaddr | wdata | {28'd0, wstrb}, 32'd0);
      reset = 1'b0;

      // Minimum latency with bvalid one cycle after bready.
      applyStimulus(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2'd2, 0, 0, 1, 2'b00, 1'b0, 1'b0, -1);
      idleCycle();
      // bvalid already waiting when bready rises.
      applyStimulus(32'h1000_0008, 32'h1234_5678, 4'h3, 2'd1, 0, 0, 0, 2'b00, 1'b0, 1'b0, -1);
      idleCycle();
      // Slow AW, then slow W.
      applyStimulus(32'h2000_0010, 32'hA5A5_5A5A, 4'hC, 2'd1, 3, 0, 0, 2'b00, 1'b0, 1'b0, -1);
      idleCycle();
      applyStimulus(32'h2000_0020, 32'h0F0F_F0F0, 4'h1, 2'd0, 0, 5, 0, 2'b00, 1'b0, 1'b0, -1);
      idleCycle();
      // SLVERR followed by OKAY.
      applyStimulus(32'h3000_0000, 32'h1111_2222, 4'hF, 2'd2, 1, 2, 1, 2'b10, 1'b0, 1'b0, -1);
      applyStimulus(32'h3000_0004, 32'h3333_4444, 4'hF, 2'd2, 0, 0, 0, 2'b00, 1'b0, 1'b0, -1);
      idleCycle();
      // Second write held during the first, accepted in the data_ok cycle.
      nx_addr = 32'h4000_0100;
      nx_data = 32'hCAFE_F00D;
      nx_strb = 4'h6;
      nx_size = 2'd1;
      applyStimulus(32'h4000_0000, 32'h5555_6666, 4'hF, 2'd2, 2, 1, 2, 2'b00, 1'b1, 1'b0, -1);
      applyStimulus(nx_addr, nx_data, nx_strb, nx_size, 0, 0, 0, 2'b00, 1'b0, 1'b1, -1);
      idleCycle();
      // Reset while waiting for the response, then a clean write.
      applyStimulus(32'h5000_0000, 32'h7777_8888, 4'hF, 2'd2, 0, 0, 2, 2'b00, 1'b0, 1'b0, 2);
      applyStimulus(32'h5000_0040, 32'h9999_AAAA, 4'hF, 2'd2, 1, 0, 1, 2'b00, 1'b0, 1'b0, -1);
      idleCycle();

      // Randomized writes, occasionally chained through a held request.
      cont = 1'b0;
      a = $urandom;
      d = $urandom;
      s = 4'($urandom);
      z = 2'($urandom_range(0, 2));
      for (int i = 0; i < 40; i++) begin
         if (!cont) begin
            repeat ($urandom_range(0, 2)) idleCycle();
         end
         hold = ($urandom_range(0, 3) == 0) && (i != 39);
         nx_addr = $urandom;
         nx_data = $urandom;
         nx_strb = 4'($urandom);
         nx_size = 2'($urandom_range(0, 2));
         applyStimulus(a, d, s, z, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                       hold, cont, -1);
         cont = hold;
         if (hold) begin
            a = nx_addr;
            d = nx_data;
            s = nx_strb;
            z = nx_size;
         end else begin
            a = $urandom;
            d = $urandom;
            s = 4'($urandom);
            z = 2'($urandom_range(0, 2));
         end
      end
      idleCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
